// File: rtl/i3c_tgt_cfg_pkg.sv
// Shared types and constants for the I3C target personality store.
package i3c_tgt_cfg_pkg;

  typedef enum logic [1:0] {
    CccSetda  = 2'd0,
    CccRstdaa = 2'd1,
    CccSetmwl = 2'd2,
    CccSetmrl = 2'd3
  } ccc_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StDone = 2'd2
  } scan_state_e;

  localparam logic [15:0] MwlResetValue = 16'd256;
  localparam logic [15:0] MrlResetValue = 16'd256;
  localparam logic [6:0]  BcastAddr     = 7'h7E;
  localparam logic [6:0]  HotJoinAddr   = 7'h02;

endpackage

// File: rtl/tgt_addr_scan.sv
// Sequential address-match engine: one table entry per cycle, lowest index wins.
// I3C_TGT_CFG_BCAST_MATCH_EN short-circuits broadcast/Hot-Join addresses without a scan.
module tgt_addr_scan
  import i3c_tgt_cfg_pkg::*;
#(
  parameter int unsigned NumTargets = 2,
  parameter int unsigned IdxW       = (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [6:0]                 addr_i,
  input  logic [NumTargets-1:0][6:0] sta_addr_i,
  input  logic [NumTargets-1:0]      sta_valid_i,
  input  logic [NumTargets-1:0][6:0] dyn_addr_i,
  input  logic [NumTargets-1:0]      dyn_valid_i,
  output logic                       idle_o,
  output logic                       ack_o,
  output logic                       hit_o,
  output logic [IdxW-1:0]            idx_o,
  output logic                       bcast_o
);

  scan_state_e     state_q, state_d;
  logic [IdxW-1:0] ptr_q;
  logic [6:0]      addr_q;
  logic            hit_q;
  logic [IdxW-1:0] idx_q;
  logic            bcast_q;
  logic            entry_hit;
  logic            last_entry;
  logic            is_bcast;

`ifdef I3C_TGT_CFG_BCAST_MATCH_EN
  assign is_bcast = (addr_i == BcastAddr) || (addr_i == HotJoinAddr);
`else
  assign is_bcast = 1'b0;
`endif

  // A valid dynamic address shadows the static one for that entry.
  always_comb begin
    entry_hit  = 1'b0;
    if (dyn_valid_i[ptr_q]) begin
      entry_hit = (dyn_addr_i[ptr_q] == addr_q);
    end else begin
      entry_hit = sta_valid_i[ptr_q] && (sta_addr_i[ptr_q] == addr_q);
    end
    last_entry = (ptr_q == IdxW'(NumTargets - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      bcast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start_i) begin
        addr_q  <= addr_i;
        ptr_q   <= '0;
        hit_q   <= 1'b0;
        idx_q   <= '0;
        bcast_q <= is_bcast;
      end else if (state_q == StScan) begin
        if (entry_hit) begin
          hit_q <= 1'b1;
          idx_q <= ptr_q;
        end else if (!last_entry) begin
          ptr_q <= ptr_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = is_bcast ? StDone : StScan;
      StScan: if (entry_hit || last_entry) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idle_o  = (state_q == StIdle);
    ack_o   = (state_q == StDone);
    hit_o   = ack_o & hit_q;
    idx_o   = ack_o ? idx_q : '0;
    bcast_o = ack_o & bcast_q;
  end

endmodule

// File: rtl/target_cfg_bank.sv
// Per-target address/limit table with CCC update port, CSR commit and match engine.
// Optional broadcast match short-cut: define I3C_TGT_CFG_BCAST_MATCH_EN.
module target_cfg_bank
  import i3c_tgt_cfg_pkg::*;
#(
  parameter int unsigned NumTargets = 2,
  parameter int unsigned IdxW       = (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7*NumTargets-1:0]  csr_sta_addr_i,
  input  logic [NumTargets-1:0]    csr_sta_valid_i,
  input  logic [7*NumTargets-1:0]  csr_dyn_addr_i,
  input  logic [NumTargets-1:0]    csr_dyn_valid_i,
  input  logic                     csr_commit_i,
  input  logic                     ccc_req_i,
  input  logic [1:0]               ccc_op_i,
  input  logic [IdxW-1:0]          ccc_idx_i,
  input  logic [15:0]              ccc_data_i,
  output logic                     ccc_ack_o,
  output logic                     ccc_err_o,
  input  logic                     match_req_i,
  input  logic [6:0]               match_addr_i,
  output logic                     match_ack_o,
  output logic                     match_hit_o,
  output logic [IdxW-1:0]          match_idx_o,
  output logic                     match_bcast_o,
  output logic [7*NumTargets-1:0]  dyn_addr_o,
  output logic [NumTargets-1:0]    dyn_valid_o,
  output logic [16*NumTargets-1:0] mwl_o,
  output logic [16*NumTargets-1:0] mrl_o,
  output logic                     busy_o
);

  logic [NumTargets-1:0][6:0]  sta_addr_q, dyn_addr_q, csr_sta_addr, csr_dyn_addr;
  logic [NumTargets-1:0]       sta_valid_q, dyn_valid_q;
  logic [NumTargets-1:0][15:0] mwl_q, mrl_q;
  logic                        ccc_ack_q, ccc_err_q, commit_pend_q;
  logic                        scan_idle, ccc_go, commit_go, match_go;
  logic                        idx_ok, setda_collide, ccc_err_d;
  ccc_op_e                     op;

  assign csr_sta_addr = csr_sta_addr_i;
  assign csr_dyn_addr = csr_dyn_addr_i;
  assign op           = ccc_op_e'(ccc_op_i);

  // The ack cycle still sees the request high; it must not start a second op.
  assign ccc_go    = scan_idle && ccc_req_i && !ccc_ack_q;
  assign commit_go = scan_idle && !ccc_go && (csr_commit_i || commit_pend_q);
  assign match_go  = scan_idle && !ccc_go && !commit_go && match_req_i;

  always_comb begin
    idx_ok        = (32'(ccc_idx_i) < NumTargets);
    setda_collide = 1'b0;
    for (int unsigned k = 0; k < NumTargets; k++) begin
      if ((32'(ccc_idx_i) != k) && dyn_valid_q[k] && (dyn_addr_q[k] == ccc_data_i[6:0])) begin
        setda_collide = 1'b1;
      end
    end
    if (op == CccRstdaa) begin
      ccc_err_d = 1'b0;
    end else begin
      ccc_err_d = !idx_ok || ((op == CccSetda) && setda_collide);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sta_addr_q    <= '0;
      sta_valid_q   <= '0;
      dyn_addr_q    <= '0;
      dyn_valid_q   <= '0;
      mwl_q         <= {NumTargets{MwlResetValue}};
      mrl_q         <= {NumTargets{MrlResetValue}};
      ccc_ack_q     <= 1'b0;
      ccc_err_q     <= 1'b0;
      commit_pend_q <= 1'b0;
    end else begin
      ccc_ack_q <= ccc_go;
      ccc_err_q <= ccc_go && ccc_err_d;
      if (commit_go) begin
        commit_pend_q <= 1'b0;
      end else if (csr_commit_i) begin
        commit_pend_q <= 1'b1;
      end
      if (commit_go) begin
        sta_addr_q  <= csr_sta_addr;
        sta_valid_q <= csr_sta_valid_i;
        dyn_addr_q  <= csr_dyn_addr;
        dyn_valid_q <= csr_dyn_valid_i;
      end else if (ccc_go && !ccc_err_d) begin
        unique case (op)
          CccSetda: begin
            dyn_addr_q[ccc_idx_i]  <= ccc_data_i[6:0];
            dyn_valid_q[ccc_idx_i] <= 1'b1;
          end
          CccRstdaa: dyn_valid_q <= '0;
          CccSetmwl: mwl_q[ccc_idx_i] <= ccc_data_i;
          CccSetmrl: mrl_q[ccc_idx_i] <= ccc_data_i;
          default: ;
        endcase
      end
    end
  end

  tgt_addr_scan #(
    .NumTargets(NumTargets),
    .IdxW      (IdxW)
  ) u_scan (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (match_go),
    .addr_i     (match_addr_i),
    .sta_addr_i (sta_addr_q),
    .sta_valid_i(sta_valid_q),
    .dyn_addr_i (dyn_addr_q),
    .dyn_valid_i(dyn_valid_q),
    .idle_o     (scan_idle),
    .ack_o      (match_ack_o),
    .hit_o      (match_hit_o),
    .idx_o      (match_idx_o),
    .bcast_o    (match_bcast_o)
  );

  assign ccc_ack_o   = ccc_ack_q;
  assign ccc_err_o   = ccc_err_q;
  assign dyn_addr_o  = dyn_addr_q;
  assign dyn_valid_o = dyn_valid_q;
  assign mwl_o       = mwl_q;
  assign mrl_o       = mrl_q;
  assign busy_o      = !scan_idle || commit_pend_q;

endmodule

// File: tb/tb_target_cfg_bank.sv
// Scoreboard bench for target_cfg_bank (NumTargets = 2); honours I3C_TGT_CFG_BCAST_MATCH_EN.
module tb_target_cfg_bank;
  localparam int unsigned N  = 2;
  localparam int unsigned IW = 1;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [7*N-1:0]  csr_sta_addr = '0, csr_dyn_addr = '0;
  logic [N-1:0]    csr_sta_valid = '0, csr_dyn_valid = '0;
  logic            csr_commit = 1'b0;
  logic            ccc_req = 1'b0;
  logic [1:0]      ccc_op = '0;
  logic [IW-1:0]   ccc_idx = '0;
  logic [15:0]     ccc_data = '0;
  logic            ccc_ack_o, ccc_err_o;
  logic            match_req = 1'b0;
  logic [6:0]      match_addr = '0;
  logic            match_ack_o, match_hit_o, match_bcast_o;
  logic [IW-1:0]   match_idx_o;
  logic [7*N-1:0]  dyn_addr_o;
  logic [N-1:0]    dyn_valid_o;
  logic [16*N-1:0] mwl_o, mrl_o;
  logic            busy_o;

  target_cfg_bank #(.NumTargets(N), .IdxW(IW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .csr_sta_addr_i(csr_sta_addr), .csr_sta_valid_i(csr_sta_valid),
    .csr_dyn_addr_i(csr_dyn_addr), .csr_dyn_valid_i(csr_dyn_valid),
    .csr_commit_i(csr_commit),
    .ccc_req_i(ccc_req), .ccc_op_i(ccc_op), .ccc_idx_i(ccc_idx), .ccc_data_i(ccc_data),
    .ccc_ack_o(ccc_ack_o), .ccc_err_o(ccc_err_o),
    .match_req_i(match_req), .match_addr_i(match_addr),
    .match_ack_o(match_ack_o), .match_hit_o(match_hit_o),
    .match_idx_o(match_idx_o), .match_bcast_o(match_bcast_o),
    .dyn_addr_o(dyn_addr_o), .dyn_valid_o(dyn_valid_o),
    .mwl_o(mwl_o), .mrl_o(mrl_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic hit;
    int   idx;
    logic bcast;
    int   lat;
  } match_exp_t;

  match_exp_t match_q[$];
  logic       ccc_q[$];
  int         m_t0;

  logic [6:0]  m_sta[N], m_dyn[N];
  logic        m_sta_v[N], m_dyn_v[N];
  logic [15:0] m_mwl[N], m_mrl[N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_sta[k] = '0; m_dyn[k] = '0; m_sta_v[k] = 1'b0; m_dyn_v[k] = 1'b0;
      m_mwl[k] = 16'd256; m_mrl[k] = 16'd256;
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < N; k++) begin
      m_sta[k]   = csr_sta_addr[k*7 +: 7];
      m_sta_v[k] = csr_sta_valid[k];
      m_dyn[k]   = csr_dyn_addr[k*7 +: 7];
      m_dyn_v[k] = csr_dyn_valid[k];
    end
  endtask

  task automatic check_table(input string tag);
    for (int k = 0; k < N; k++) begin
      check({tag, "_dyn_addr"}, dyn_addr_o[k*7 +: 7], m_dyn[k]);
      check({tag, "_dyn_valid"}, dyn_valid_o[k], m_dyn_v[k]);
      check({tag, "_mwl"}, mwl_o[k*16 +: 16], m_mwl[k]);
      check({tag, "_mrl"}, mrl_o[k*16 +: 16], m_mrl[k]);
    end
  endtask

  task automatic set_csr(input logic [6:0] s0, input logic [6:0] s1, input logic [1:0] sv,
                         input logic [6:0] d0, input logic [6:0] d1, input logic [1:0] dv);
    csr_sta_addr  = {s1, s0};
    csr_sta_valid = sv;
    csr_dyn_addr  = {d1, d0};
    csr_dyn_valid = dv;
  endtask

  task automatic do_commit(input string tag);
    csr_commit = 1'b1;
    tick();
    csr_commit = 1'b0;
    model_commit();
    check_table(tag);
  endtask

  function automatic logic model_ccc_err(input logic [1:0] op, input int idx, input logic [15:0] data);
    if (op == 2'd1) return 1'b0;
    if (op != 2'd0) return 1'b0;
    for (int k = 0; k < N; k++)
      if (k != idx && m_dyn_v[k] && m_dyn[k] == data[6:0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_ccc_apply(input logic [1:0] op, input int idx, input logic [15:0] data);
    case (op)
      2'd0: begin m_dyn[idx] = data[6:0]; m_dyn_v[idx] = 1'b1; end
      2'd1: for (int k = 0; k < N; k++) m_dyn_v[k] = 1'b0;
      2'd2: m_mwl[idx] = data;
      default: m_mrl[idx] = data;
    endcase
  endtask

  task automatic do_ccc(input string tag, input logic [1:0] op, input int idx, input logic [15:0] data);
    logic e, exp_e;
    int   lat;
    exp_e = model_ccc_err(op, idx, data);
    ccc_q.push_back(exp_e);
    ccc_op = op; ccc_idx = IW'(idx); ccc_data = data; ccc_req = 1'b1;
    lat = 0;
    while (!ccc_ack_o && lat < 10) begin tick(); lat++; end
    e = ccc_q.pop_front();
    if (!ccc_ack_o) check({tag, "_timeout"}, 0, 1);
    else begin
      check({tag, "_err"}, ccc_err_o, e);
      check({tag, "_lat"}, lat, 1);
    end
    ccc_req = 1'b0;
    if (!e) model_ccc_apply(op, idx, data);
    tick();
  endtask

  function automatic match_exp_t model_match(input logic [6:0] a);
    match_exp_t r;
    logic found;
    r.hit = 1'b0; r.idx = 0; r.bcast = 1'b0; r.lat = N + 1;
`ifdef I3C_TGT_CFG_BCAST_MATCH_EN
    if (a == 7'h7E || a == 7'h02) begin
      r.bcast = 1'b1; r.lat = 1;
      return r;
    end
`endif
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && (m_dyn_v[k] ? (m_dyn[k] == a) : (m_sta_v[k] && m_sta[k] == a))) begin
        found = 1'b1; r.hit = 1'b1; r.idx = k; r.lat = k + 2;
      end
    end
    return r;
  endfunction

  task automatic start_match(input logic [6:0] a);
    match_q.push_back(model_match(a));
    match_addr = a;
    match_req  = 1'b1;
    m_t0 = cyc;
  endtask

  task automatic finish_match(input string tag);
    match_exp_t e;
    int guard = 0;
    while (!match_ack_o && guard < 20) begin tick(); guard++; end
    e = match_q.pop_front();
    if (!match_ack_o) check({tag, "_timeout"}, 0, 1);
    else begin
      check({tag, "_hit"}, match_hit_o, e.hit);
      check({tag, "_idx"}, match_idx_o, e.idx);
      check({tag, "_bcast"}, match_bcast_o, e.bcast);
      check({tag, "_lat"}, cyc - m_t0, e.lat);
    end
    match_req = 1'b0;
  endtask

  task automatic do_match(input string tag, input logic [6:0] a);
    start_match(a);
    finish_match(tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    model_reset();
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    check_table("reset");
    check("reset_busy", busy_o, 0);
    check("reset_ccc_ack", ccc_ack_o, 0);
    check("reset_match_ack", match_ack_o, 0);

    // Static addresses only: target0 0x21, target1 0x30.
    set_csr(7'h21, 7'h30, 2'b11, 7'h00, 7'h00, 2'b00);
    do_commit("commit1");
    do_match("m_sta1", 7'h30);
    do_match("m_sta0", 7'h21);
    do_match("m_miss", 7'h55);

    do_ccc("setda0", 2'd0, 0, 16'h0010);
    do_ccc("setda1_coll", 2'd0, 1, 16'h0010);
    check_table("after_coll");
    do_ccc("setda1", 2'd0, 1, 16'h0011);
    do_ccc("setda0_self", 2'd0, 0, 16'h0010);
    check_table("after_setda");
    do_match("m_dyn0", 7'h10);
    do_match("m_dyn1", 7'h11);
    do_match("m_sta_shadowed", 7'h30);

    do_ccc("setmwl0_zero", 2'd2, 0, 16'h0000);
    do_ccc("setmrl1", 2'd3, 1, 16'h1234);
    do_ccc("setmwl1", 2'd2, 1, 16'hFFFF);
    check_table("after_len");

    do_ccc("rstdaa", 2'd1, 1, 16'h0000);
    check_table("after_rstdaa");
    do_match("m_old_dyn", 7'h10);
    do_match("m_fallback", 7'h30);

    // Commit arriving mid-scan waits until one cycle after DONE -> IDLE.
    set_csr(7'h21, 7'h30, 2'b11, 7'h44, 7'h45, 2'b01);
    start_match(7'h44);
    tick();
    csr_commit = 1'b1;
    tick();
    csr_commit = 1'b0;
    check("scan_busy", busy_o, 1);
    check("scan_table_hold", dyn_valid_o, 2'b00);
    finish_match("m_during_commit");
    check("done_busy", busy_o, 1);
    check("done_table_hold", dyn_valid_o, 2'b00);
    tick();
    check("idle1_busy", busy_o, 1);
    check("idle1_table_hold", dyn_valid_o, 2'b00);
    tick();
    check("commit_busy_fall", busy_o, 0);
    model_commit();
    check_table("late_commit");
    do_match("m_new_dyn", 7'h44);

    // CCC and commit in the same IDLE cycle: CCC first, commit right after.
    set_csr(7'h21, 7'h30, 2'b11, 7'h00, 7'h00, 2'b00);
    ccc_q.push_back(model_ccc_err(2'd3, 0, 16'h0040));
    ccc_op = 2'd3; ccc_idx = '0; ccc_data = 16'h0040; ccc_req = 1'b1;
    csr_commit = 1'b1;
    tick();
    csr_commit = 1'b0;
    check("cc_ack", ccc_ack_o, 1);
    check("cc_err", ccc_err_o, ccc_q.pop_front());
    check("cc_busy", busy_o, 1);
    check("cc_dyn_hold", dyn_valid_o, 2'b01);
    check("cc_mrl", mrl_o[15:0], 16'h0040);
    ccc_req = 1'b0;
    model_ccc_apply(2'd3, 0, 16'h0040);
    tick();
    check("cc_busy_fall", busy_o, 0);
    check("cc_no_reack", ccc_ack_o, 0);
    model_commit();
    check_table("cc_commit");

    do_match("m_bcast", 7'h7E);
    do_match("m_hotjoin", 7'h02);

    // Reset mid-scan with a pending commit: no ack, pending dropped.
    set_csr(7'h21, 7'h30, 2'b11, 7'h33, 7'h34, 2'b11);
    match_addr = 7'h30; match_req = 1'b1;
    tick();
    csr_commit = 1'b1;
    tick();
    csr_commit = 1'b0;
    rst_ni = 1'b0;
    match_req = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    acks = 0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      acks += int'(match_ack_o) + int'(ccc_ack_o);
    end
    check("rst_no_ack", acks, 0);
    check("rst_busy_after", busy_o, 0);
    model_reset();
    check_table("rst_mid");

    check("sb_match_empty", match_q.size(), 0);
    check("sb_ccc_empty", ccc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/target_cfg_bank.md
# target_cfg_bank

Parametrised per-target addressing and limits store for the I3C target side. It holds `NumTargets` independent target personalities, each with its own static/dynamic address, MWL and MRL. Each personality is loaded atomically from CSR shadow inputs and updated at run time by CCC handlers. A sequential address-match engine tells the target FSM which personality, if any, is being addressed.

## Interface
- `NumTargets`, default 2: number of personalities, 1..8.
- `IdxW`, default `$clog2(NumTargets)` (minimum 1): width of the index fields.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `csr_sta_addr_i`  in  7*NumTargets  static address per target, CSR value.
- `csr_sta_valid_i`  in  NumTargets  static address valid flags.
- `csr_dyn_addr_i`  in  7*NumTargets  dynamic address preload.
- `csr_dyn_valid_i`  in  NumTargets  dynamic address preload valid flags.
- `csr_commit_i`  in  1  pulse; copies all `csr_*` inputs into the table.
- `ccc_req_i`  in  1  CCC update request; held until `ccc_ack_o`.
- `ccc_op_i`  in  2  operation: 0 SETDA, 1 RSTDAA, 2 SETMWL, 3 SETMRL.
- `ccc_idx_i`  in  IdxW  target index of the update.
- `ccc_data_i`  in  16  new address in [6:0], or the new length.
- `ccc_ack_o`  out  1  one-cycle acknowledge.
- `ccc_err_o`  out  1  valid with ack; SETDA address collision or index out of range.
- `match_req_i`  in  1  match request; `match_addr_i` is sampled when it is accepted.
- `match_addr_i`  in  7  address taken from the bus.
- `match_ack_o`  out  1  one-cycle result strobe.
- `match_hit_o`, `match_idx_o`, `match_bcast_o`  out  1/IdxW/1  result, valid with the ack.
- `dyn_addr_o`  out  7*NumTargets  registered dynamic addresses.
- `dyn_valid_o`  out  NumTargets  registered dynamic address valid flags.
- `mwl_o`, `mrl_o`  out  16*NumTargets  max write and max read lengths.
- `busy_o`  out  1  high while a scan is in progress or a commit is pending.

## Operation
- Reset values:
  - all address fields 0 and all valid flags 0;
  - `mwl_o`/`mrl_o` 256 per target;
  - all acks, `ccc_err_o`, match outputs and `busy_o` 0;
  - FSM in IDLE.
- Scan FSM has three states:
  - IDLE: accepts a match request, a CCC request or a pending commit.
  - SCAN: compares entry `ptr` against the latched address, one entry per cycle.
  - DONE: drives the ack for one cycle, then returns to IDLE.
- Entry k hits when `dyn_valid[k]` is set and `dyn_addr[k]` equals the latched address. If the dynamic address is not valid, the entry hits when `sta_valid[k]` is set and `sta_addr[k]` equals the latched address.
- The scan stops at the first hit, so the lowest index wins. A miss is declared after entry `NumTargets-1`, with `match_idx_o` = 0.
- Arbitration in IDLE, highest priority first:
  1. CCC request;
  2. pending commit;
  3. match request.
- `csr_commit_i` arriving while the FSM is not in IDLE, or while a CCC request is served, sets the pending flag. The commit is applied on the first eligible IDLE cycle. Further pulses while pending merge into that one commit.
- SETDA:
  - If the address equals the valid dynamic address of another index, the operation errors and the table is unchanged.
  - Otherwise it writes the address and sets valid.
- RSTDAA clears `dyn_valid` of every target, ignoring `ccc_idx_i`.
- SETMWL/SETMRL write the 16-bit value unchanged; a value of 0 is stored as-is.
- An index ≥ `NumTargets` sets `ccc_err_o`, and nothing is written.
- The table is never modified while in SCAN, so a scan sees a stable table.

## Timing
- CCC: a request seen in IDLE at cycle n gets the ack at n+1, with the table updated at the same edge. The request must drop after the ack; a still-high request at n+2 is a new operation.
- Match, with the request accepted at cycle n:
  - a hit at index k gives the ack at n+k+2;
  - a miss gives the ack at n+NumTargets+1.
- `match_req_i` is ignored outside IDLE. The requester holds the request until the ack.
- Commit: the pending commit applies one cycle after IDLE is re-entered. `busy_o` falls in the same cycle.
- Reset asserted mid-scan or mid-update aborts the operation. No ack is issued, and the pending commit is dropped.

## Configuration
- `I3C_TGT_CFG_BCAST_MATCH_EN` defined: a match on 7'h7E or 7'h02 returns `match_bcast_o`=1 and hit=0, with the ack at n+1 and no scan. 7'h02 is the Hot-Join address.
- Not defined: `match_bcast_o` is tied 0, and those addresses are scanned like any other.

## Structure
- The `i3c_tgt_cfg_pkg` package holds:
  - the `ccc_op_e` enum;
  - the `scan_state_e` enum;
  - `MwlResetValue` = 256 and `MrlResetValue` = 256;
  - the broadcast and Hot-Join address constants.
- Sub-module `tgt_addr_scan` contains the FSM, the pointer and the comparator, and reads the table through index-selected muxes. The top level owns the table registers and the arbitration.

## Test plan
- Reset, then read the outputs: `mwl_o`/`mrl_o` = 256, `dyn_valid_o` = 0, `busy_o` = 0.
- Commit with target 1 sta = 0x30 valid, then match 0x30: hit, idx 1, ack 3 cycles after acceptance (n+3 for `NumTargets`=2).
- SETDA idx0 = 0x10, then SETDA idx1 = 0x10: the second op gives `ccc_err_o`=1 and `dyn_addr_o[1]` is unchanged.
- `csr_commit_i` pulsed during a scan: `busy_o` stays high, and the table changes only 1 cycle after DONE→IDLE.
- RSTDAA after two SETDAs: both dyn valid flags clear; a match on the old dyn address falls back to the static address, or misses.
- With the macro defined, match 0x7E: `match_bcast_o`=1 and ack at n+1. Without it: a miss at n+NumTargets+1.
